wb_config_ctrl: RTL

Parametrised Wishbone slave that loads the fabric's per-column configuration shift chains. It generalises the fixed 2-region × 4-column configurators to NUM_REGIONS regions of COLS columns each. It serialises each 32-bit write into COLS-wide slices, tracks the number of shifted slices against CHAIN_LEN, and issues a guarded latch pulse. Several instances may share one bus: data_o and ack_o are zero outside the instance's address window, so top-level OR-combining is safe.

---
 rtl/wb_config_pkg.sv | 29 ++
 rtl/cfg_slice_shifter.sv | 73 +++++++
 rtl/wb_config_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/wb_config_pkg.sv
// Shared definitions for the configuration-chain Wishbone slave.
package wb_config_pkg;

  // Register offsets (addr[7:0])
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_DATA   = 8'h04;
  localparam logic [7:0] OFF_CMD    = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;

  // STATUS bit positions
  localparam int ST_BUSY    = 0;
  localparam int ST_READY   = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_CNT_LSB = 16;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SET, S_ACK} state_t;

  // Slices carried by one 32-bit word
  function automatic int slices_per_word(input int cols);
    return 32 / cols;
  endfunction

  // Width of a counter that must reach slices_per_word(cols)
  function automatic int slice_idx_w(input int cols);
    return $clog2(32 / cols + 1);
  endfunction

endpackage

// File: rtl/cfg_slice_shifter.sv
// Serialises a data word into COLS-wide slices on the target regions and
// drives the one-cycle latch pulse. All outputs are registered.
module cfg_slice_shifter
  import wb_config_pkg::*;
#(
  parameter int NUM_REGIONS = 2,
  parameter int COLS        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          latch,
  input  logic [NUM_REGIONS-1:0]        tmask,
  input  logic [31:0]                   data,
  output logic                          done,
  output logic [NUM_REGIONS-1:0]        cen_o,
  output logic [NUM_REGIONS*COLS-1:0]   shift_o,
  output logic [NUM_REGIONS*COLS-1:0]   set_o
);

  localparam int SPW = slices_per_word(COLS);
  localparam int IW  = slice_idx_w(COLS);

  logic [31:0]                 word_q;
  logic [IW-1:0]               idx_q;
  logic                        active_q;
  logic [COLS-1:0]             slice_sel;
  logic [NUM_REGIONS*COLS-1:0] col_mask;
  logic [NUM_REGIONS*COLS-1:0] slice_bus;

  // First slice comes straight from the bus word, later ones from the register
  assign slice_sel = load ? data[COLS-1:0] : word_q[COLS-1:0];

  for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_reg
    assign col_mask[r*COLS +: COLS]  = {COLS{tmask[r]}};
    assign slice_bus[r*COLS +: COLS] = slice_sel;
  end

  // Last slice of the word is currently on shift_o
  assign done = active_q && (idx_q == IW'(SPW));

  // Slice sequencing and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      cen_o    <= '0;
      shift_o  <= '0;
      set_o    <= '0;
    end else begin
      set_o <= latch ? col_mask : '0;
      if (load) begin
        word_q   <= data >> COLS;
        idx_q    <= IW'(1);
        active_q <= 1'b1;
        cen_o    <= tmask;
        shift_o  <= slice_bus & col_mask;
      end else if (active_q) begin
        if (done) begin
          active_q <= 1'b0;
          cen_o    <= '0;
          shift_o  <= '0;
        end else begin
          word_q  <= word_q >> COLS;
          idx_q   <= idx_q + IW'(1);
          shift_o <= slice_bus & col_mask;
        end
      end
    end
  end

endmodule

// File: rtl/wb_config_ctrl.sv
// Wishbone slave loading per-column configuration shift chains.
// Outputs are zero outside the address window so instances can be OR-ed.
module wb_config_ctrl
  import wb_config_pkg::*;
#(
  parameter int          NUM_REGIONS = 2,
  parameter int          COLS        = 4,
  parameter int          CHAIN_LEN   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_addr_i,
  input  logic [31:0]                 wbs_data_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_data_o,
  output logic [NUM_REGIONS-1:0]      cen_o,
  output logic [NUM_REGIONS*COLS-1:0] shift_o,
  output logic [NUM_REGIONS*COLS-1:0] set_o,
  output logic                        busy_o
);

  state_t             state_q, state_d;
  logic               ack_q, ack_d;
  logic               drop_q;
  logic               bcast_q;
  logic [7:0]         region_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;
  logic [31:0]        rdata_q, rd_mux;
  logic [NUM_REGIONS-1:0] tmask;
  logic               hit, accept, ready, empty, sh_done;
  logic               wr_ctrl, wr_data, wr_cmd, wr_status, do_latch, latch_ok;
  logic [7:0]         off;
  logic               unused_sel;

  assign unused_sel = &{1'b0, wbs_sel_i[3:2]};

  assign off       = wbs_addr_i[7:0];
  assign hit       = (wbs_addr_i[31:8] == BASE_ADDR[31:8]);
  assign accept    = (state_q == S_IDLE) && wbs_cyc_i && wbs_stb_i && hit;
  assign wr_ctrl   = accept && wbs_we_i && (off == OFF_CTRL);
  assign wr_data   = accept && wbs_we_i && (off == OFF_DATA);
  assign wr_cmd    = accept && wbs_we_i && (off == OFF_CMD);
  assign wr_status = accept && wbs_we_i && (off == OFF_STATUS);
  assign ready     = {16'h0, count_q} >= 32'(CHAIN_LEN);
  assign do_latch  = wr_cmd && wbs_data_i[0];
  assign latch_ok  = do_latch && ready;
  assign empty     = ~|tmask;

  // Target regions: all on broadcast, otherwise the selected one if it exists
  always_comb begin
    tmask = '0;
    if (bcast_q) tmask = '1;
    else
      for (int r = 0; r < NUM_REGIONS; r++)
        if (region_q == 8'(r)) tmask[r] = 1'b1;
  end

  // Read data, captured at acceptance (FSM is IDLE then, so busy reads 0)
  always_comb begin
    rd_mux = '0;
    if (off == OFF_CTRL) begin
      rd_mux[0]    = bcast_q;
      rd_mux[15:8] = region_q;
    end else if (off == OFF_STATUS) begin
      rd_mux[ST_BUSY]               = (state_q != S_IDLE);
      rd_mux[ST_READY]              = ready;
      rd_mux[ST_ERR]                = err_q;
      rd_mux[ST_CNT_LSB +: CNT_W]   = count_q;
    end
  end

  // Next state and ack; a dropped cycle during SHIFT suppresses the ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = wr_data ? S_SHIFT : (latch_ok ? S_SET : S_ACK);
      S_SHIFT: if (sh_done) state_d = S_ACK;
      S_SET:   state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ack_d = (state_d == S_ACK) &&
            !((state_q == S_SHIFT) && (drop_q || !wbs_cyc_i));
  end

  // FSM, ack, cyc-drop tracking and read data registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      drop_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      if (accept) drop_q <= 1'b0;
      else if ((state_q == S_SHIFT) && !wbs_cyc_i) drop_q <= 1'b1;
      if (accept) rdata_q <= wbs_we_i ? 32'h0 : rd_mux;
    end
  end

  // CTRL, slice count and sticky error
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      bcast_q  <= 1'b0;
      region_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        if (wbs_sel_i[0]) bcast_q  <= wbs_data_i[0];
        if (wbs_sel_i[1]) region_q <= wbs_data_i[15:8];
      end
      // Latch owns the count when both latch and clear are written
      if (wr_ctrl || (wr_cmd && wbs_data_i[1] && !wbs_data_i[0]))
        count_q <= '0;
      else if (state_q == S_SET)
        count_q <= '0;
      else if ((state_q == S_SHIFT) && !empty && (count_q != '1))
        count_q <= count_q + CNT_W'(1);
      if (wr_status && wbs_data_i[ST_ERR])
        err_q <= 1'b0;
      else if ((wr_data && empty) || (do_latch && !ready))
        err_q <= 1'b1;
    end
  end

  cfg_slice_shifter #(
    .NUM_REGIONS (NUM_REGIONS),
    .COLS        (COLS)
  ) u_shifter (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .load    (wr_data),
    .latch   (latch_ok),
    .tmask   (tmask),
    .data    (wbs_data_i),
    .done    (sh_done),
    .cen_o   (cen_o),
    .shift_o (shift_o),
    .set_o   (set_o)
  );

  assign wbs_ack_o  = ack_q;
  assign wbs_data_o = ack_q ? rdata_q : 32'h0;
  assign busy_o     = (state_q != S_IDLE);

endmodule
